// File: rtl/bist_signature_analyzer_pkg.sv
// Shared definitions for the BIST output-response analyzer: FSM encoding
// and default MISR constants.
package bist_signature_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } sa_state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/bist_signature_analyzer_misr_step.sv
// One MISR compaction step: shift with polynomial feedback, then fold the
// response into the low bits. Purely combinational; shared with the LFSR side.
module misr_step #(
    parameter int                SIG_W  = 16,
    parameter int                RESP_W = 1,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
    input  logic [SIG_W-1:0]  i_sig,
    input  logic [RESP_W-1:0] i_resp,
    output logic [SIG_W-1:0]  o_sig_n
);

    logic [SIG_W-1:0] w_resp_ext;
    logic [SIG_W-1:0] w_fb;

    // Zero-extension written this way so RESP_W == SIG_W needs no zero-width replication
    always_comb begin
        w_resp_ext               = '0;
        w_resp_ext[RESP_W-1:0]   = i_resp;
    end

    assign w_fb    = i_sig[SIG_W-1] ? POLY : '0;
    assign o_sig_n = {i_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ w_resp_ext;

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST output-response analyzer: compacts PAT_CNT CUT responses into a MISR
// signature and compares it against a golden value.
module bist_signature_analyzer
    import bist_signature_analyzer_pkg::*;
#(
    parameter int               RESP_W  = 1,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
    parameter int               PAT_CNT = 32,
    parameter int               CNT_W   = $clog2(PAT_CNT+1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_resp_valid,
    input  logic [RESP_W-1:0] i_resp,
    input  logic [SIG_W-1:0]  i_golden,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [SIG_W-1:0]  o_signature,
    output logic [CNT_W-1:0]  o_count
);

    sa_state_t        r_state, w_state_n;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass;
    logic [SIG_W-1:0] w_sig_n;
    logic             w_accept;
    logic             w_last;

    misr_step #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr_step (
        .i_sig   (r_sig),
        .i_resp  (i_resp),
        .o_sig_n (w_sig_n)
    );

    assign w_accept = (r_state == ST_RUN) && i_resp_valid;
    assign w_last   = (r_cnt == CNT_W'(PAT_CNT - 1));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (i_start)             w_state_n = ST_RUN;
            ST_RUN:  if (w_accept && w_last)  w_state_n = ST_CMP;
            ST_CMP:                           w_state_n = ST_DONE;
            ST_DONE: if (i_start)             w_state_n = ST_RUN;
            default:                          w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_sig  <= SEED;
                        r_cnt  <= '0;
                        r_pass <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_resp_valid) begin
                        r_sig <= w_sig_n;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CMP:  r_pass <= (r_sig == i_golden);
                default: ;
            endcase
        end
    end

    // Status flags decode straight from the state register
    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_CMP);
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = r_pass;
    assign o_signature = r_sig;
    assign o_count     = r_cnt;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Randomized bench for bist_signature_analyzer against a GF(2) polynomial
// remainder model of the signature.
module tb_bist_signature_analyzer;

    localparam int          SIG_W   = 16;
    localparam int          PAT_CNT = 32;
    localparam int          CNT_W   = $clog2(PAT_CNT+1);
    localparam logic [15:0] SEED    = 16'h0000;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              i_resp_valid;
    logic [0:0]        i_resp;
    logic [SIG_W-1:0]  i_golden;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic [SIG_W-1:0]  o_signature;
    logic [CNT_W-1:0]  o_count;

    int n_chk = 0;
    int n_err = 0;

    bit          resp_q[$];
    logic [15:0] fixed_sig[int];

    bist_signature_analyzer dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_resp_valid (i_resp_valid),
        .i_resp       (i_resp),
        .i_golden     (i_golden),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_signature  (o_signature),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Signature = (SEED * x^n + sum r_i x^(n-1-i)) mod (x^16 + POLY), by long division
    function automatic logic [15:0] sig_ref(input bit b[$]);
        int rem;
        rem = int'(SEED);
        foreach (b[i]) begin
            rem = (rem << 1) | int'(b[i]);
            if ((rem & 32'h10000) != 0) rem = rem ^ 32'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic run_session(input logic [15:0] golden, input bit use_model_golden,
                               input int gap_max, input bit start_noise);
        bit          acc[$];
        logic [15:0] m;
        logic [15:0] g;
        acc = {};
        m   = sig_ref(acc);
        g   = use_model_golden ? 16'h0 : golden;
        if (use_model_golden) g = sig_ref(resp_q) ^ golden;
        @(negedge i_clk);
        i_golden = g; i_start = 1'b1; i_resp_valid = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_done", 32'(o_done), 0);
        chk("start_pass", 32'(o_pass), 0);
        chk("start_sig",  32'(o_signature), 32'(SEED));
        chk("start_cnt",  32'(o_count), 0);
        foreach (resp_q[k]) begin
            repeat ($urandom_range(0, gap_max)) begin
                i_resp_valid = 1'b0;
                i_resp       = 1'($urandom);
                i_start      = start_noise ? 1'($urandom) : 1'b0;
                @(negedge i_clk);
                chk("gap_sig", 32'(o_signature), 32'(m));
                chk("gap_cnt", 32'(o_count), acc.size());
            end
            i_start      = 1'b0;
            i_resp_valid = 1'b1;
            i_resp       = resp_q[k];
            @(negedge i_clk);
            acc.push_back(resp_q[k]);
            m = sig_ref(acc);
            chk("acc_sig", 32'(o_signature), 32'(m));
            chk("acc_cnt", 32'(o_count), acc.size());
            if (fixed_sig.exists(k + 1)) chk("fixed_sig", 32'(o_signature), 32'(fixed_sig[k + 1]));
        end
        // In CMP now; a stray valid here must not disturb the result
        chk("cmp_busy", 32'(o_busy), 1);
        chk("cmp_done", 32'(o_done), 0);
        i_resp_valid = 1'b1;
        i_resp       = 1'($urandom);
        @(negedge i_clk);
        i_resp_valid = 1'b0;
        chk("done_done", 32'(o_done), 1);
        chk("done_busy", 32'(o_busy), 0);
        chk("done_pass", 32'(o_pass), 32'(m == g));
        chk("done_sig",  32'(o_signature), 32'(m));
        chk("done_cnt",  32'(o_count), PAT_CNT);
        i_resp_valid = 1'b1;
        @(negedge i_clk);
        i_resp_valid = 1'b0;
        chk("hold_done", 32'(o_done), 1);
        chk("hold_pass", 32'(o_pass), 32'(m == g));
        chk("hold_sig",  32'(o_signature), 32'(m));
        chk("hold_cnt",  32'(o_count), PAT_CNT);
    endtask

    task automatic fill_random();
        resp_q = {};
        repeat (PAT_CNT) resp_q.push_back(1'($urandom));
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_resp_valid = 1'b0; i_resp = '0; i_golden = '0;
        #12;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_pass", 32'(o_pass), 0);
        chk("rst_sig",  32'(o_signature), 0);
        chk("rst_cnt",  32'(o_count), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_resp_valid = ~i_resp_valid;
            i_resp       = 1'($urandom);
            @(negedge i_clk);
            chk("idle_sig",  32'(o_signature), 0);
            chk("idle_cnt",  32'(o_count), 0);
            chk("idle_busy", 32'(o_busy), 0);
            chk("idle_done", 32'(o_done), 0);
        end
        i_resp_valid = 1'b0;

        // All-zero responses, golden 0
        resp_q = {};
        repeat (PAT_CNT) resp_q.push_back(1'b0);
        run_session(16'h0000, 1'b0, 0, 1'b0);

        // Single error bit, known intermediate signatures
        resp_q = {};
        resp_q.push_back(1'b1);
        repeat (PAT_CNT - 1) resp_q.push_back(1'b0);
        fixed_sig[1]  = 16'h0001;
        fixed_sig[16] = 16'h8000;
        fixed_sig[17] = 16'h1021;
        run_session(16'h0000, 1'b1, 0, 1'b0);
        run_session(16'h0001, 1'b1, 0, 1'b0);
        fixed_sig.delete();

        // Gapped valid with start noise during RUN
        fill_random();
        run_session(16'h0000, 1'b1, 3, 1'b1);

        // Restart directly from DONE with all-zero again
        resp_q = {};
        repeat (PAT_CNT) resp_q.push_back(1'b0);
        run_session(16'h0000, 1'b0, 1, 1'b0);

        // Reset mid-session after 10 accepts
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) begin
            i_resp_valid = 1'b1;
            i_resp       = 1'($urandom);
            @(negedge i_clk);
        end
        i_resp_valid = 1'b0;
        chk("pre_rst_cnt", 32'(o_count), 10);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_done", 32'(o_done), 0);
        chk("arst_pass", 32'(o_pass), 0);
        chk("arst_sig",  32'(o_signature), 0);
        chk("arst_cnt",  32'(o_count), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_busy", 32'(o_busy), 0);

        // Random sessions, mix of matching and random goldens
        for (int s = 0; s < 6; s++) begin
            fill_random();
            if (s % 2 == 0) run_session(16'h0000, 1'b1, 2, 1'b1);
            else            run_session(16'($urandom), 1'b0, 2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
